rv32i_alu_issue: RTL and testbench
==================================

# rv32i_alu_issue

Sequential issue front end for `rv32ialu`.
- Accepts one decoded RISC-V operation at a time over a valid/ready handshake.
- Maps opcode/funct fields onto the ALU's 3-bit control encoding and drives the ALU operand ports from registers for a programmable number of settle cycles.
- Captures the ALU result and zero flag and returns them over a second valid/ready handshake.
- Sits between the multi-cycle datapath's decode stage and the combinational ALU, which it instantiates externally.

## Interface
Parameters:
- SETTLE_CYCLES, 1, number of EXEC cycles operands are held before capture (legal 1..15).

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid && in_ready at a rising edge
- in_opcode  in  7  instruction opcode
- in_funct3  in  3  funct3
- in_funct7_5  in  1  instruction bit 30
- in_rs1_val  in  32  rs1 operand
- in_rs2_val  in  32  rs2 operand
- in_imm  in  32  sign-extended immediate
- alu_a  out  32  to ALU A
- alu_b  out  32  to ALU B
- alu_ctrl  out  3  to ALU control
- alu_y  in  32  from ALU Y
- alu_zero  in  1  from ALU zero
- out_valid  out  1  response valid
- out_ready  in  1  response consumed when out_valid && out_ready at a rising edge
- out_result  out  32  captured ALU result
- out_zero  out  1  captured zero flag
- out_taken  out  1  branch taken
- out_illegal  out  1  unsupported encoding

## Operation
ALU control encoding: SUB=000, ADD=001, AND=010, OR=011, SLL=100, SRL=101, SLT=110, reserved=111 (ALU yields 0).

Decode, latched at acceptance:
- **opcode 0110011** (register-register), B=rs2:
  - funct3 000 with bit30=0 → ADD; with bit30=1 → SUB
  - 111 → AND
  - 110 → OR
  - 001 with bit30=0 → SLL
  - 101 with bit30=0 → SRL
  - 010 → SLT
- **opcode 0010011** (immediate), B=imm:
  - 000 → ADD
  - 111 → AND
  - 110 → OR
  - 010 → SLT
  - 001 with bit30=0 → SLL
  - 101 with bit30=0 → SRL
- **Illegal:** any other combination. Sets alu_ctrl=111 and out_illegal=1; the operation still runs, so out_result=0 and out_zero=1.
- A is always rs1.

FSM:
- **IDLE**
  - in_ready=1.
  - On accept: register operands and ctrl, load counter with SETTLE_CYCLES-1, go to EXEC.
- **EXEC**
  - alu_a, alu_b and alu_ctrl are driven from registers and do not change.
  - While counter≠0, decrement.
  - When counter=0, capture alu_y and alu_zero into out_result and out_zero, compute out_taken, go to RESP.
- **RESP**
  - out_valid=1.
  - out_result, out_zero, out_taken and out_illegal are held stable until out_ready.
  - On handshake, go to IDLE.
  - in_ready=0 throughout RESP. No request overlaps a pending response.

Boundaries:
- in_valid in EXEC or RESP is ignored. The requester must hold it.
- out_ready asserted early (before out_valid) has no effect.
- Reset low at any edge, in any state, forces IDLE and discards the transaction.

## Timing
- Reset values:
  - in_ready=0 while rst_n=0, then 1 in IDLE.
  - out_valid=0, out_result=0, out_zero=0, out_taken=0, out_illegal=0.
  - alu_a=0, alu_b=0, alu_ctrl=111.
- Latency: accept at edge k, capture at edge k+SETTLE_CYCLES, out_valid high after edge k+SETTLE_CYCLES.
- Minimum spacing between accepts: SETTLE_CYCLES+2 cycles when out_ready is held at 1.
- in_ready and out_valid decode directly from state. There is no combinational path from in_valid or out_ready to any output.
- SETTLE_CYCLES values outside 1..15 are a configuration error. Implementation flags this with an elaboration-time check.

## Configuration
- `RV32I_ALU_ISSUE_BRANCH_EN` defined:
  - opcode 1100011 is decoded with ctrl=SUB and B=rs2.
  - funct3 000 (BEQ): out_taken=alu_zero.
  - funct3 001 (BNE): out_taken=!alu_zero.
  - Other branch funct3 values are illegal.
  - out_taken=0 for all non-branch operations.
- Undefined: opcode 1100011 is illegal and out_taken is tied to 0.

## Test plan
- Reset, then release with SETTLE_CYCLES=1 and out_ready=1. Issue R-type ADD of 7 and 5 → out_valid after 1 cycle, out_result=12, out_zero=0.
- R-type SUB of 9 and 9 → out_result=0, out_zero=1. I-type SLT of rs1=-3 and imm=2 → out_result=1.
- SETTLE_CYCLES=4, SLLI rs1=1 imm=31 → alu inputs stable for 4 EXEC cycles, then out_result=0x80000000.
- out_ready low for 5 cycles → response held unchanged and in_ready=0 throughout. Release → IDLE next cycle.
- XOR (funct3 100, opcode 0110011) → alu_ctrl=111, out_illegal=1, out_result=0.
- With the macro defined: BNE 3 vs 4 → out_taken=1; BEQ 3 vs 4 → out_taken=0. Assert rst_n low mid-EXEC → next cycle IDLE with out_valid=0.

Source files
------------

// File: rtl/rv32i_alu_issue.sv
// Sequential issue front end for an external combinational RV32I ALU: decode, hold operands, capture, respond.
// Define RV32I_ALU_ISSUE_BRANCH_EN to decode BEQ/BNE (opcode 1100011) and drive out_taken.
module rv32i_alu_issue #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  in_opcode,
    input  logic [2:0]  in_funct3,
    input  logic        in_funct7_5,
    input  logic [31:0] in_rs1_val,
    input  logic [31:0] in_rs2_val,
    input  logic [31:0] in_imm,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_ctrl,
    input  logic [31:0] alu_y,
    input  logic        alu_zero,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        out_zero,
    output logic        out_taken,
    output logic        out_illegal
);
    localparam logic [2:0] CTRL_SUB  = 3'b000;
    localparam logic [2:0] CTRL_ADD  = 3'b001;
    localparam logic [2:0] CTRL_AND  = 3'b010;
    localparam logic [2:0] CTRL_OR   = 3'b011;
    localparam logic [2:0] CTRL_SLL  = 3'b100;
    localparam logic [2:0] CTRL_SRL  = 3'b101;
    localparam logic [2:0] CTRL_SLT  = 3'b110;
    localparam logic [2:0] CTRL_RSVD = 3'b111;

    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
`ifdef RV32I_ALU_ISSUE_BRANCH_EN
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
`endif

    localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle_cycles
        $error("rv32i_alu_issue: SETTLE_CYCLES must be in 1..15");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_RESP
    } state_t;

    typedef struct packed {
        logic [2:0] ctrl;
        logic       use_imm;
        logic       illegal;
`ifdef RV32I_ALU_ISSUE_BRANCH_EN
        logic       is_branch;
        logic       br_ne;
`endif
    } dec_t;

    // Unsupported encodings fall through with ctrl=RSVD so the ALU yields zero.
    function automatic dec_t decode(input logic [6:0] opcode, input logic [2:0] funct3,
                                    input logic bit30);
        dec_t d;
        d         = '0;
        d.ctrl    = CTRL_RSVD;
        d.illegal = 1'b1;
        case (opcode)
            OP_REG: begin
                case (funct3)
                    3'b000: begin d.ctrl = bit30 ? CTRL_SUB : CTRL_ADD; d.illegal = 1'b0; end
                    3'b111: begin d.ctrl = CTRL_AND; d.illegal = 1'b0; end
                    3'b110: begin d.ctrl = CTRL_OR;  d.illegal = 1'b0; end
                    3'b010: begin d.ctrl = CTRL_SLT; d.illegal = 1'b0; end
                    3'b001: if (!bit30) begin d.ctrl = CTRL_SLL; d.illegal = 1'b0; end
                    3'b101: if (!bit30) begin d.ctrl = CTRL_SRL; d.illegal = 1'b0; end
                    default: ;
                endcase
            end
            OP_IMM: begin
                d.use_imm = 1'b1;
                case (funct3)
                    3'b000: begin d.ctrl = CTRL_ADD; d.illegal = 1'b0; end
                    3'b111: begin d.ctrl = CTRL_AND; d.illegal = 1'b0; end
                    3'b110: begin d.ctrl = CTRL_OR;  d.illegal = 1'b0; end
                    3'b010: begin d.ctrl = CTRL_SLT; d.illegal = 1'b0; end
                    3'b001: if (!bit30) begin d.ctrl = CTRL_SLL; d.illegal = 1'b0; end
                    3'b101: if (!bit30) begin d.ctrl = CTRL_SRL; d.illegal = 1'b0; end
                    default: ;
                endcase
            end
`ifdef RV32I_ALU_ISSUE_BRANCH_EN
            OP_BRANCH: begin
                if (funct3 == 3'b000 || funct3 == 3'b001) begin
                    d.ctrl      = CTRL_SUB;
                    d.illegal   = 1'b0;
                    d.is_branch = 1'b1;
                    d.br_ne     = funct3[0];
                end
            end
`endif
            default: ;
        endcase
        return d;
    endfunction

    state_t     state;
    state_t     state_next;
    logic [3:0] cnt;
    logic       illegal_q;
    dec_t       dec;

    assign dec = decode(in_opcode, in_funct3, in_funct7_5);

    assign in_ready  = rst_n && (state == S_IDLE);
    assign out_valid = (state == S_RESP);

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (in_valid)  state_next = S_EXEC;
            S_EXEC:  if (cnt == '0) state_next = S_RESP;
            S_RESP:  if (out_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

`ifdef RV32I_ALU_ISSUE_BRANCH_EN
    logic is_branch_q;
    logic br_ne_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            is_branch_q <= 1'b0;
            br_ne_q     <= 1'b0;
            out_taken   <= 1'b0;
        end else if (state == S_IDLE && in_valid) begin
            is_branch_q <= dec.is_branch;
            br_ne_q     <= dec.br_ne;
        end else if (state == S_EXEC && cnt == '0) begin
            out_taken   <= is_branch_q && (br_ne_q ? !alu_zero : alu_zero);
        end
    end
`else
    assign out_taken = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            illegal_q   <= 1'b0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_ctrl    <= CTRL_RSVD;
            out_result  <= '0;
            out_zero    <= 1'b0;
            out_illegal <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        alu_a     <= in_rs1_val;
                        alu_b     <= dec.use_imm ? in_imm : in_rs2_val;
                        alu_ctrl  <= dec.ctrl;
                        illegal_q <= dec.illegal;
                        cnt       <= CNT_LOAD;
                    end
                end
                // EXEC: operands stay put while the ALU settles
                S_EXEC: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        out_result  <= alu_y;
                        out_zero    <= alu_zero;
                        out_illegal <= illegal_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rv32i_alu_issue.sv
// Bench for rv32i_alu_issue: two instances (SETTLE_CYCLES 1 and 4) looped back through a behavioural ALU,
// directed steps with a scoreboard of expected responses.
`timescale 1ns/1ps
module tb_rv32i_alu_issue;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, out_ready, sel;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7_5;
    logic [31:0] rs1, rs2, imm;

    logic        v1, r1, ov1, oz1, ot1, oi1, z1;
    logic [31:0] a1, b1, y1, res1;
    logic [2:0]  c1;
    logic        v4, r4, ov4, oz4, ot4, oi4, z4;
    logic [31:0] a4, b4, y4, res4;
    logic [2:0]  c4;

    function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [2:0] c);
        case (c)
            3'b000:  return a - b;
            3'b001:  return a + b;
            3'b010:  return a & b;
            3'b011:  return a | b;
            3'b100:  return a << b[4:0];
            3'b101:  return a >> b[4:0];
            3'b110:  return {31'd0, $signed(a) < $signed(b)};
            default: return 32'd0;
        endcase
    endfunction

    assign y1 = alu_model(a1, b1, c1);
    assign z1 = (y1 == 32'd0);
    assign y4 = alu_model(a4, b4, c4);
    assign z4 = (y4 == 32'd0);

    rv32i_alu_issue #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(r1),
        .in_opcode(opcode), .in_funct3(funct3), .in_funct7_5(funct7_5),
        .in_rs1_val(rs1), .in_rs2_val(rs2), .in_imm(imm),
        .alu_a(a1), .alu_b(b1), .alu_ctrl(c1), .alu_y(y1), .alu_zero(z1),
        .out_valid(ov1), .out_ready(out_ready), .out_result(res1), .out_zero(oz1),
        .out_taken(ot1), .out_illegal(oi1)
    );

    rv32i_alu_issue #(.SETTLE_CYCLES(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(r4),
        .in_opcode(opcode), .in_funct3(funct3), .in_funct7_5(funct7_5),
        .in_rs1_val(rs1), .in_rs2_val(rs2), .in_imm(imm),
        .alu_a(a4), .alu_b(b4), .alu_ctrl(c4), .alu_y(y4), .alu_zero(z4),
        .out_valid(ov4), .out_ready(out_ready), .out_result(res4), .out_zero(oz4),
        .out_taken(ot4), .out_illegal(oi4)
    );

    logic        m_ready, m_valid, m_zero, m_taken, m_illegal;
    logic [31:0] m_a, m_b, m_result;
    logic [2:0]  m_ctrl;

    always_comb begin
        if (sel) begin
            m_ready = r4; m_valid = ov4; m_zero = oz4; m_taken = ot4; m_illegal = oi4;
            m_a = a4; m_b = b4; m_result = res4; m_ctrl = c4;
        end else begin
            m_ready = r1; m_valid = ov1; m_zero = oz1; m_taken = ot1; m_illegal = oi1;
            m_a = a1; m_b = b1; m_result = res1; m_ctrl = c1;
        end
    end

    typedef struct {
        logic [31:0] res;
        logic        zero;
        logic        taken;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input string tag, input logic s, input logic [6:0] op,
                         input logic [2:0] f3, input logic f7,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                         input logic use_imm, input logic [2:0] ctrl,
                         input logic [31:0] e_res, input logic e_zero, input logic e_taken,
                         input logic e_ill, input int settle, input int hold);
        exp_t e;
        int   lat;
        @(negedge clk);
        sel = s; opcode = op; funct3 = f3; funct7_5 = f7;
        rs1 = a; rs2 = b; imm = im;
        out_ready = (hold == 0);
        if (s) v4 = 1'b1; else v1 = 1'b1;
        sb.push_back('{e_res, e_zero, e_taken, e_ill});
        check({tag, "/in_ready_idle"}, m_ready, 1'b1);
        @(posedge clk); #1;
        v1 = 1'b0; v4 = 1'b0;
        lat = 0;
        while (!m_valid && lat < 40) begin
            check({tag, "/exec_ops"}, {m_ready, m_a, m_b, m_ctrl},
                  {1'b0, a, (use_imm ? im : b), ctrl});
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "/latency"}, lat, settle);
        if (sb.size() == 0) begin
            check({tag, "/scoreboard_empty"}, 1'b1, 1'b0);
        end else begin
            e = sb.pop_front();
            for (int i = 0; i < hold; i++) begin
                check({tag, "/held"}, {m_valid, m_ready, m_result, m_zero, m_taken, m_illegal},
                      {2'b10, e.res, e.zero, e.taken, e.ill});
                @(posedge clk); #1;
            end
            check({tag, "/result"}, m_result, e.res);
            check({tag, "/flags"}, {m_valid, m_zero, m_taken, m_illegal},
                  {1'b1, e.zero, e.taken, e.ill});
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check({tag, "/back_idle"}, {m_valid, m_ready}, 2'b01);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; out_ready = 1'b1; sel = 1'b0; v1 = 1'b0; v4 = 1'b0;
        opcode = '0; funct3 = '0; funct7_5 = 1'b0; rs1 = '0; rs2 = '0; imm = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_dut1", {r1, ov1, res1, oz1, ot1, oi1, a1, b1, c1},
              {6'b0, 32'd0, 32'd0, 32'd0, 3'b111} >> 0);
        check("reset_dut4", {r4, ov4, res4, oz4, ot4, oi4, a4, b4, c4},
              {2'b00, 32'd0, 4'b0000, 32'd0, 32'd0, 3'b111});
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("ready_after_reset", {r1, r4}, 2'b11);

        issue("add", 1'b0, 7'b0110011, 3'b000, 1'b0, 32'd7, 32'd5, 32'd0, 1'b0, 3'b001,
              32'd12, 1'b0, 1'b0, 1'b0, 1, 0);
        issue("sub", 1'b0, 7'b0110011, 3'b000, 1'b1, 32'd9, 32'd9, 32'd0, 1'b0, 3'b000,
              32'd0, 1'b1, 1'b0, 1'b0, 1, 0);
        issue("slti", 1'b0, 7'b0010011, 3'b010, 1'b0, 32'hFFFF_FFFD, 32'd100, 32'd2, 1'b1, 3'b110,
              32'd1, 1'b0, 1'b0, 1'b0, 1, 0);
        issue("and", 1'b0, 7'b0110011, 3'b111, 1'b0, 32'h0000_F0F0, 32'h0000_FF00, 32'd0, 1'b0, 3'b010,
              32'h0000_F000, 1'b0, 1'b0, 1'b0, 1, 0);
        issue("ori", 1'b0, 7'b0010011, 3'b110, 1'b0, 32'h0000_0100, 32'd0, 32'h0000_0011, 1'b1, 3'b011,
              32'h0000_0111, 1'b0, 1'b0, 1'b0, 1, 0);
        issue("xor_illegal", 1'b0, 7'b0110011, 3'b100, 1'b0, 32'd6, 32'd3, 32'd0, 1'b0, 3'b111,
              32'd0, 1'b1, 1'b0, 1'b1, 1, 0);
        issue("sra_illegal", 1'b0, 7'b0110011, 3'b101, 1'b1, 32'h8000_0000, 32'd4, 32'd0, 1'b0, 3'b111,
              32'd0, 1'b1, 1'b0, 1'b1, 1, 0);
`ifdef RV32I_ALU_ISSUE_BRANCH_EN
        issue("bne_3_4", 1'b0, 7'b1100011, 3'b001, 1'b0, 32'd3, 32'd4, 32'd0, 1'b0, 3'b000,
              32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 1, 0);
        issue("beq_3_4", 1'b0, 7'b1100011, 3'b000, 1'b0, 32'd3, 32'd4, 32'd0, 1'b0, 3'b000,
              32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1, 0);
        issue("beq_5_5", 1'b0, 7'b1100011, 3'b000, 1'b0, 32'd5, 32'd5, 32'd0, 1'b0, 3'b000,
              32'd0, 1'b1, 1'b1, 1'b0, 1, 0);
        issue("blt_illegal", 1'b0, 7'b1100011, 3'b100, 1'b0, 32'd1, 32'd2, 32'd0, 1'b0, 3'b111,
              32'd0, 1'b1, 1'b0, 1'b1, 1, 0);
`else
        issue("branch_illegal", 1'b0, 7'b1100011, 3'b001, 1'b0, 32'd3, 32'd4, 32'd0, 1'b0, 3'b111,
              32'd0, 1'b1, 1'b0, 1'b1, 1, 0);
`endif

        issue("slli_s4", 1'b1, 7'b0010011, 3'b001, 1'b0, 32'd1, 32'd0, 32'd31, 1'b1, 3'b100,
              32'h8000_0000, 1'b0, 1'b0, 1'b0, 4, 0);
        issue("srl_hold", 1'b1, 7'b0110011, 3'b101, 1'b0, 32'h8000_0000, 32'd4, 32'd0, 1'b0, 3'b101,
              32'h0800_0000, 1'b0, 1'b0, 1'b0, 4, 5);

        // Reset in the middle of EXEC must drop the transaction.
        @(negedge clk);
        sel = 1'b1; opcode = 7'b0110011; funct3 = 3'b000; funct7_5 = 1'b0;
        rs1 = 32'd1; rs2 = 32'd1; v4 = 1'b1;
        @(posedge clk); #1;
        v4 = 1'b0;
        check("midrst_in_exec", {m_ready, m_valid, m_ctrl}, {2'b00, 3'b001});
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrst_forced", {m_ready, m_valid, m_ctrl, m_a}, {2'b00, 3'b111, 32'd0});
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("midrst_idle", {m_ready, m_valid}, 2'b10);
        repeat (6) @(posedge clk);
        #1;
        check("midrst_discarded", {m_ready, m_valid}, 2'b10);

        issue("after_rst", 1'b1, 7'b0010011, 3'b000, 1'b0, 32'd40, 32'd0, 32'd2, 1'b1, 3'b001,
              32'd42, 1'b0, 1'b0, 1'b0, 4, 0);

        check("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
